// File: rtl/mult_seq_nxn_pkg.sv
// Shared types and helpers for the digit-serial multiplier (mult_seq_nxn).
// The optional signed mode is enabled by defining MULT_SEQ_SIGNED_EN.
package mult_seq_pkg;

    // Controller states. FIX is only reachable when the signed mode is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width of the digit-pair index; never below one bit so WIDTH == DIGIT still works.
    function automatic int idx_width(input int cycles);
        if (cycles > 1)
            return $clog2(cycles);
        else
            return 1;
    endfunction

endpackage

// File: rtl/mult_seq_nxn_if.sv
// Start/ready/done handshake bundle for mult_seq_nxn.
// Carries signed_mode only when MULT_SEQ_SIGNED_EN is defined.
//
// Handshake: an operation is accepted on a rising clk edge where start=1 and
// ready=1; dataa/datab (and signed_mode) are captured on that edge only.
// done_flag is a one-cycle pulse in the cycle product_out first shows the new
// result; valid stays high until the next accepted start.
interface mult_seq_nxn_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     dataa;
    logic [WIDTH-1:0]     datab;
`ifdef MULT_SEQ_SIGNED_EN
    logic                 signed_mode;
`endif
    logic                 ready;
    logic                 done_flag;
    logic                 valid;
    logic [2*WIDTH-1:0]   product_out;

    modport master (
        output start,
        output dataa,
        output datab,
`ifdef MULT_SEQ_SIGNED_EN
        output signed_mode,
`endif
        input  ready,
        input  done_flag,
        input  valid,
        input  product_out
    );

    modport slave (
        input  start,
        input  dataa,
        input  datab,
`ifdef MULT_SEQ_SIGNED_EN
        input  signed_mode,
`endif
        output ready,
        output done_flag,
        output valid,
        output product_out
    );
endinterface

// File: rtl/mult_seq_nxn_digit.sv
// Combinational DIGIT x DIGIT -> 2*DIGIT unsigned multiplier (one partial product).
module mult_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0]   a,
    input  logic [DIGIT-1:0]   b,
    output logic [2*DIGIT-1:0] p
);
    // Operands widened first so the full product is kept.
    assign p = (2*DIGIT)'(a) * (2*DIGIT)'(b);
endmodule

// File: rtl/mult_seq_nxn.sv
// Digit-serial WIDTH x WIDTH multiplier: one DIGIT x DIGIT partial product per
// clock, shifted into a 2*WIDTH accumulator over N_DIG*N_DIG RUN cycles.
// Define MULT_SEQ_SIGNED_EN to add the signed_mode input and the FIX state
// (sign-magnitude multiply, then a final conditional negate).
module mult_seq_nxn
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic           clk,
    input  logic           reset_a,
    mult_seq_nxn_if.slave  bus,
    output state_t         state_dbg
);
    localparam int N_DIG  = WIDTH / DIGIT;
    localparam int CYCLES = N_DIG * N_DIG;
    localparam int IDX_W  = idx_width(CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic                 ready_int;
    logic                 accept;
    logic                 last_run;

    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [IDX_W-1:0]     idx;
    logic [2*WIDTH-1:0]   product_r;
    logic                 valid_r;
    logic                 done_r;

    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    int                   i_pos;
    int                   j_pos;
    logic [DIGIT-1:0]     a_dig;
    logic [DIGIT-1:0]     b_dig;
    logic [2*DIGIT-1:0]   pp;
    logic [2*WIDTH-1:0]   pp_shift;
    logic [2*WIDTH-1:0]   acc_next;

`ifdef MULT_SEQ_SIGNED_EN
    logic                 neg_r;
    logic                 neg_in;
`endif

    assign accept   = ready_int & bus.start;
    assign last_run = (state == RUN) && (idx == IDX_LAST);

    // Operand capture values: magnitudes in signed mode (-2^(W-1) maps to 2^(W-1)).
`ifdef MULT_SEQ_SIGNED_EN
    always_comb begin
        a_in   = bus.dataa;
        b_in   = bus.datab;
        neg_in = 1'b0;
        if (bus.signed_mode) begin
            if (bus.dataa[WIDTH-1]) a_in = -bus.dataa;
            if (bus.datab[WIDTH-1]) b_in = -bus.datab;
            neg_in = bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1];
        end
    end
`else
    // Unsigned build: operands are captured as-is.
    always_comb begin
        a_in = bus.dataa;
        b_in = bus.datab;
    end
`endif

    // Digit selection and alignment of the current partial product.
    always_comb begin
        i_pos    = int'(idx) / N_DIG;
        j_pos    = int'(idx) % N_DIG;
        a_dig    = DIGIT'(a_reg >> (i_pos * DIGIT));
        b_dig    = DIGIT'(b_reg >> (j_pos * DIGIT));
        pp_shift = (2*WIDTH)'(pp) << ((i_pos + j_pos) * DIGIT);
        acc_next = acc + pp_shift;
    end

    mult_digit #(.DIGIT(DIGIT)) u_digit (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                if (last_run) begin
`ifdef MULT_SEQ_SIGNED_EN
                    state_next = FIX;
`else
                    state_next = DONE;
`endif
                end
            end
            FIX:  state_next = DONE;
            DONE: if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Controller outputs: ready whenever idle or holding a result.
    always_comb begin
        ready_int = (state == IDLE) || (state == DONE);
    end

    // Datapath: capture, accumulate, and publish the result on completion.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            idx       <= '0;
            product_r <= '0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
            neg_r     <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                a_reg   <= a_in;
                b_reg   <= b_in;
                acc     <= '0;
                idx     <= '0;
                valid_r <= 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
                neg_r   <= neg_in;
`endif
            end else if (state == RUN) begin
                acc <= acc_next;
                idx <= idx + 1'b1;
`ifndef MULT_SEQ_SIGNED_EN
                if (last_run) begin
                    product_r <= acc_next;
                    valid_r   <= 1'b1;
                    done_r    <= 1'b1;
                end
`endif
            end
`ifdef MULT_SEQ_SIGNED_EN
            else if (state == FIX) begin
                product_r <= neg_r ? -acc : acc;
                valid_r   <= 1'b1;
                done_r    <= 1'b1;
            end
`endif
        end
    end

    assign bus.ready       = ready_int;
    assign bus.done_flag   = done_r;
    assign bus.valid       = valid_r;
    assign bus.product_out = product_r;
    assign state_dbg       = state;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Self-checking bench for mult_seq_nxn: an 8-bit and a 4-bit instance share
// clock and reset. Directed table, random ops against an arithmetic model,
// and hand-written multi-cycle corner sequences.
module tb_mult_seq_nxn;
    import mult_seq_pkg::*;

`ifdef MULT_SEQ_SIGNED_EN
    localparam int LAT8 = 17;
    localparam int LAT4 = 5;
`else
    localparam int LAT8 = 16;
    localparam int LAT4 = 4;
`endif

    logic   clk = 1'b0;
    logic   reset_a;
    state_t st8;
    state_t st4;

    int n_tests = 0;
    int n_fail  = 0;

    mult_seq_nxn_if #(.WIDTH(8)) bus8 ();
    mult_seq_nxn_if #(.WIDTH(4)) bus4 ();

    mult_seq_nxn #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk       (clk),
        .reset_a   (reset_a),
        .bus       (bus8),
        .state_dbg (st8)
    );

    mult_seq_nxn #(.WIDTH(4), .DIGIT(2)) u4 (
        .clk       (clk),
        .reset_a   (reset_a),
        .bus       (bus4),
        .state_dbg (st4)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the interpreted operands.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int sa;
        int sb;
        if (sm) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        return 16'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one op on the 8-bit unit and count edges from accept to done_flag.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm, output int lat);
        bus8.start = 1'b1;
        bus8.dataa = a;
        bus8.datab = b;
`ifdef MULT_SEQ_SIGNED_EN
        bus8.signed_mode = sm;
`endif
        tick();
        bus8.start = 1'b0;
        bus8.dataa = 8'($urandom);
        bus8.datab = 8'($urandom);
`ifdef MULT_SEQ_SIGNED_EN
        bus8.signed_mode = ~sm;
`endif
        check("ready_low_in_run", 64'(bus8.ready), 64'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus8.done_flag && lat < 100);
    endtask

    task automatic set4(input int k);
        bus4.dataa = 4'(k >> 4);
        bus4.datab = 4'(k);
    endtask

    initial begin
        int lat;
        int cnt;
        logic [7:0] ra;
        logic [7:0] rb;
        logic rs;

        reset_a    = 1'b0;
        bus8.start = 1'b0;
        bus8.dataa = '0;
        bus8.datab = '0;
        bus4.start = 1'b0;
        bus4.dataa = '0;
        bus4.datab = '0;
`ifdef MULT_SEQ_SIGNED_EN
        bus8.signed_mode = 1'b0;
        bus4.signed_mode = 1'b0;
`endif

        // Reset state
        repeat (3) tick();
        check("rst_ready",   64'(bus8.ready), 64'd1);
        check("rst_done",    64'(bus8.done_flag), 64'd0);
        check("rst_valid",   64'(bus8.valid), 64'd0);
        check("rst_product", 64'(bus8.product_out), 64'd0);
        check("rst_state",   64'(st8), 64'(IDLE));
        check("rst4_ready",  64'(bus4.ready), 64'd1);
        reset_a = 1'b1;
        tick();

        // Directed table
        tbl.push_back('{8'd255, 8'd255, 1'b0, 16'd65025});
        tbl.push_back('{8'd0,   8'd0,   1'b0, 16'd0});
        tbl.push_back('{8'd1,   8'd1,   1'b0, 16'd1});
        tbl.push_back('{8'd12,  8'd13,  1'b0, 16'd156});
        tbl.push_back('{8'd255, 8'd1,   1'b0, 16'd255});
        tbl.push_back('{8'd128, 8'd2,   1'b0, 16'd256});
        tbl.push_back('{8'd170, 8'd85,  1'b0, 16'd14450});
        tbl.push_back('{8'd15,  8'd17,  1'b0, 16'd255});
        tbl.push_back('{8'd200, 8'd200, 1'b0, 16'd40000});
`ifdef MULT_SEQ_SIGNED_EN
        tbl.push_back('{8'hFD,  8'd5,   1'b1, 16'hFFF1});
        tbl.push_back('{8'h80,  8'h80,  1'b1, 16'd16384});
        tbl.push_back('{8'd127, 8'h80,  1'b1, 16'hC080});
        tbl.push_back('{8'hFF,  8'hFF,  1'b1, 16'd1});
`endif
        foreach (tbl[n]) begin
            run8(tbl[n].a, tbl[n].b, tbl[n].sm, lat);
            check("tbl_latency", 64'(lat), 64'(LAT8));
            check("tbl_product", 64'(bus8.product_out), 64'(tbl[n].exp));
            check("tbl_valid",   64'(bus8.valid), 64'd1);
            check("tbl_ready",   64'(bus8.ready), 64'd1);
            tick();
            check("tbl_done_pulse", 64'(bus8.done_flag), 64'd0);
            check("tbl_hold",    64'(bus8.product_out), 64'(tbl[n].exp));
        end

        // Random ops against the model
        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
`ifdef MULT_SEQ_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run8(ra, rb, rs, lat);
            check("rnd_latency", 64'(lat), 64'(LAT8));
            check("rnd_product", 64'(bus8.product_out), 64'(ref_mul(ra, rb, rs)));
        end

        // Start during RUN is ignored; operand changes after accept have no effect
        bus8.start = 1'b1;
        bus8.dataa = 8'd12;
        bus8.datab = 8'd13;
`ifdef MULT_SEQ_SIGNED_EN
        bus8.signed_mode = 1'b0;
`endif
        tick();
        bus8.start = 1'b0;
        bus8.dataa = 8'd77;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 5) begin
                bus8.start = 1'b1;
                bus8.dataa = 8'd99;
            end else begin
                bus8.start = 1'b0;
            end
        end while (!bus8.done_flag && lat < 100);
        bus8.start = 1'b0;
        check("ign_latency", 64'(lat), 64'(LAT8));
        check("ign_product", 64'(bus8.product_out), 64'd156);

        // Start in the done_flag cycle is accepted; product holds until next completion
        bus8.start = 1'b1;
        bus8.dataa = 8'd7;
        bus8.datab = 8'd9;
        tick();
        bus8.start = 1'b0;
        check("b2b_valid_drop", 64'(bus8.valid), 64'd0);
        check("b2b_old_hold",   64'(bus8.product_out), 64'd156);
        check("b2b_state",      64'(st8), 64'(RUN));
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus8.done_flag && lat < 100);
        check("b2b_latency", 64'(lat), 64'(LAT8));
        check("b2b_product", 64'(bus8.product_out), 64'd63);

        // Asynchronous reset mid-operation
        bus8.start = 1'b1;
        bus8.dataa = 8'd50;
        bus8.datab = 8'd60;
        tick();
        bus8.start = 1'b0;
        repeat (7) tick();
        check("pre_rst_state", 64'(st8), 64'(RUN));
        #2;
        reset_a = 1'b0;
        #1;
        check("arst_ready",   64'(bus8.ready), 64'd1);
        check("arst_done",    64'(bus8.done_flag), 64'd0);
        check("arst_valid",   64'(bus8.valid), 64'd0);
        check("arst_product", 64'(bus8.product_out), 64'd0);
        check("arst_state",   64'(st8), 64'(IDLE));
        tick();
        tick();
        reset_a = 1'b1;
        tick();
        run8(8'd0, 8'd200, 1'b0, lat);
        check("post_rst0_latency", 64'(lat), 64'(LAT8));
        check("post_rst0_product", 64'(bus8.product_out), 64'd0);
        run8(8'd1, 8'd200, 1'b0, lat);
        check("post_rst1_latency", 64'(lat), 64'(LAT8));
        check("post_rst1_product", 64'(bus8.product_out), 64'd200);

        // 4-bit unit: all 256 pairs back-to-back with start held high
        bus4.start = 1'b1;
        set4(0);
        tick();
        set4(1);
        for (int k = 0; k < 256; k++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
                if (k > 0 && cnt == 1) set4(k + 1);
            end while (!bus4.done_flag && cnt < 50);
            if (k == 255) bus4.start = 1'b0;
            check("w4_period",  64'(cnt), 64'((k == 0) ? LAT4 : LAT4 + 1));
            check("w4_product", 64'(bus4.product_out), 64'((k >> 4) * (k & 15)));
        end
        tick();
        tick();
        check("w4_idle_done", 64'(st4), 64'(DONE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
